sync_fifo_fwft: RTL and testbench

- Parametrised single-clock FIFO; successor to the team's basic synchronous FIFO.
- Adds:
  - selectable first-word-fall-through (FWFT) or standard read latency
  - guarded pointers (no overwrite on full, no pop on empty)
  - programmable almost-full / almost-empty thresholds
  - sticky overflow/underflow error flags
- Sits between producer/consumer pipelines, e.g. hash-job and result buffering, where back-pressure must be lossless.

---
 rtl/sync_fifo_pkg.sv | 21 ++
 rtl/fifo_dp_ram.sv | 31 +++
 rtl/sync_fifo_fwft.sv | 148 ++++++++++++++
 tb/tb_sync_fifo_fwft.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the FWFT synchronous FIFO: a constant-evaluable
// clog2 and the default geometry/threshold values used by sync_fifo_fwft.
package sync_fifo_pkg;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_DATA_WIDTH    = 8;
  localparam int DEF_ADDR_WIDTH    = 4;
  localparam int DEPTH             = 1 << DEF_ADDR_WIDTH;
  localparam int DEF_AFULL_THRESH  = DEPTH - 2;
  localparam int DEF_AEMPTY_THRESH = 2;

endpackage

// File: rtl/fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, single
// clock, no reset on the array or read register (block-RAM inferable).
// Ports:
//   clk_i    clock
//   we_i     write enable      waddr_i / wdata_i  write address / data
//   re_i     read enable       raddr_i            read address
//   rdata_o  registered read data (updates only on re_i, read-before-write)
module fifo_dp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with optional first-word-fall-through, guarded pointers,
// registered almost-full/almost-empty flags and sticky overflow/underflow.
// Ports:
//   clk, rst_n (async, active-low)
//   data_in / we     write data / request (rejected while full)
//   re               read/pop request (rejected while empty)
//   data_out         head word (FWFT=1) or last read word (FWFT=0)
//   occupants        words held, 0..DEPTH (includes prefetched words)
//   empty, full, almost_full, almost_empty  status flags
//   overflow, underflow  sticky error flags, cleared by clr_err
module sync_fifo_fwft
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter bit FWFT          = 1'b1,
  parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  we,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   occupants,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int FIFO_DEPTH = 1 << ADDR_WIDTH;
  localparam int PW         = clog2(FIFO_DEPTH) + 1;
  localparam logic [PW-1:0] FULL_LIM = PW'(FIFO_DEPTH);
  localparam logic [PW-1:0] AF_LIM   = PW'(AFULL_THRESH);
  localparam logic [PW-1:0] AE_LIM   = PW'(AEMPTY_THRESH);

  if (!(AEMPTY_THRESH > 0 && AEMPTY_THRESH < AFULL_THRESH && AFULL_THRESH <= FIFO_DEPTH))
  begin : g_bad_thresh
    $error("sync_fifo_fwft: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
  end

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         occ_q, occ_d;
  logic                  s1_valid_q, s1_valid_d;   // RAM read in flight
  logic                  out_valid_q, out_valid_d; // output register holds a word
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic                  full_q, empty_q, afull_q, aempty_q;
  logic                  ovf_q, unf_q;
  logic                  wr_ok, rd_ok, ram_has, ram_rd, out_free, ld_out;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign wr_ok   = we & ~full_q;
  assign rd_ok   = re & ~empty_q;
  assign ram_has = (wr_ptr_q != rd_ptr_q);

  always_comb begin
    out_free    = 1'b0;
    ld_out      = 1'b0;
    ram_rd      = 1'b0;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    if (FWFT) begin
      // Two-stage prefetch: RAM read register feeds the output register,
      // and both stages advance together on a pop so streaming is 1/cycle.
      out_free    = ~out_valid_q | rd_ok;
      ld_out      = s1_valid_q & out_free;
      ram_rd      = ram_has & (~s1_valid_q | out_free);
      s1_valid_d  = ram_rd | (s1_valid_q & ~out_free);
      out_valid_d = ld_out | (out_valid_q & ~rd_ok);
    end else begin
      // Standard mode: RAM read on the accepted pop, copied out one edge later
      // so data_out has a reset value and holds between reads.
      ram_rd      = rd_ok;
      ld_out      = s1_valid_q;
      s1_valid_d  = rd_ok;
      out_valid_d = out_valid_q | ld_out;
    end

    out_d    = ld_out ? ram_rdata : out_q;
    wr_ptr_d = wr_ok  ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = ram_rd ? rd_ptr_q + PW'(1) : rd_ptr_q;

    case ({wr_ok, rd_ok})
      2'b10:   occ_d = occ_q + PW'(1);
      2'b01:   occ_d = occ_q - PW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      full_q      <= (occ_d == FULL_LIM);
      empty_q     <= FWFT ? ~out_valid_d : (occ_d == '0);
      afull_q     <= (occ_d >= AF_LIM);
      aempty_q    <= (occ_d <= AE_LIM);
      // A new error in the same cycle as clr_err keeps the flag set.
      ovf_q       <= (we & full_q)  | (ovf_q & ~clr_err);
      unf_q       <= (re & empty_q) | (unf_q & ~clr_err);
    end
  end

  fifo_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_ok),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (data_in),
    .re_i    (ram_rd),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (ram_rdata)
  );

  assign data_out     = out_q;
  assign occupants    = occ_q;
  assign empty        = empty_q;
  assign full         = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       we = 1'b0;
  logic       re = 1'b0;
  logic       clr_err = 1'b0;

  logic [7:0] f1_dout, f0_dout;
  logic [4:0] f1_occ, f0_occ;
  logic f1_empty, f1_full, f1_af, f1_ae, f1_ovf, f1_unf;
  logic f0_empty, f0_full, f0_af, f0_ae, f0_ovf, f0_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .we(we), .re(re),
    .data_out(f1_dout), .occupants(f1_occ), .empty(f1_empty), .full(f1_full),
    .almost_full(f1_af), .almost_empty(f1_ae), .overflow(f1_ovf),
    .underflow(f1_unf), .clr_err(clr_err)
  );

  sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1'b0)) u_std (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .we(we), .re(re),
    .data_out(f0_dout), .occupants(f0_occ), .empty(f0_empty), .full(f0_full),
    .almost_full(f0_af), .almost_empty(f0_ae), .overflow(f0_ovf),
    .underflow(f0_unf), .clr_err(clr_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs from a falling edge; returns at the next
  // falling edge, i.e. half a cycle after the rising edge that used them.
  task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
    we = w; re = r; data_in = d; clr_err = c;
    @(negedge clk);
    we = 1'b0; re = 1'b0; clr_err = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] popped, last_pop;

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-stream
    for (int k = 0; k < 5; k++) step(1, 0, 8'h30 + 8'(k), 0);
    check_eq("pre_rst_occ", f1_occ, 5);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_occ_f1", f1_occ, 0);
    check_eq("rst_occ_f0", f0_occ, 0);
    check_eq("rst_empty_f1", f1_empty, 1);
    check_eq("rst_empty_f0", f0_empty, 1);
    check_eq("rst_dout_f1", f1_dout, 0);
    check_eq("rst_ae_af", {f1_ae, f1_af, f1_full}, 3'b100);
    check_eq("rst_err", {f1_ovf, f1_unf, f0_ovf, f0_unf}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // FWFT latency: write at edge N, visible after N+2
    step(1, 0, 8'hA5, 0);
    check_eq("lat_n_empty_f1", f1_empty, 1);
    check_eq("lat_n_occ_f1", f1_occ, 1);
    check_eq("lat_n_empty_f0", f0_empty, 0);
    step(0, 0, 0, 0);
    check_eq("lat_n1_empty_f1", f1_empty, 1);
    step(0, 0, 0, 0);
    check_eq("lat_n2_empty_f1", f1_empty, 0);
    check_eq("lat_n2_dout_f1", f1_dout, 8'hA5);
    check_eq("lat_n2_dout_f0", f0_dout, 0);
    step(0, 1, 0, 0);
    check_eq("lat_pop_empty_f1", f1_empty, 1);
    check_eq("lat_pop_occ_f1", f1_occ, 0);
    check_eq("lat_pop_occ_f0", f0_occ, 0);
    step(0, 0, 0, 0);
    check_eq("lat_dout_f0", f0_dout, 8'hA5);

    // Standard read latency and hold
    step(1, 0, 8'h11, 0);
    step(1, 0, 8'h22, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check_eq("std_head_f1", f1_dout, 8'h11);
    step(0, 1, 0, 0);
    check_eq("std_read_edge_f0", f0_dout, 8'hA5);
    step(0, 0, 0, 0);
    check_eq("std_first_f0", f0_dout, 8'h11);
    step(0, 0, 0, 0);
    check_eq("std_hold_f0", f0_dout, 8'h11);
    check_eq("std_head2_f1", f1_dout, 8'h22);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("std_second_f0", f0_dout, 8'h22);
    check_eq("std_empty", {f1_empty, f0_empty, f1_occ, f0_occ}, 12'hC00);

    // Fill to full, overflow, full with simultaneous we & re
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 8'(i), 0);
      check_eq("fill_occ_f1", f1_occ, i + 1);
      check_eq("fill_occ_f0", f0_occ, i + 1);
      if (i == 12) check_eq("af_13", {f1_af, f0_af}, 2'b00);
      if (i == 13) check_eq("af_14", {f1_af, f0_af}, 2'b11);
      if (i == 14) check_eq("full_15", {f1_full, f0_full}, 2'b00);
    end
    check_eq("full_16", {f1_full, f0_full}, 2'b11);
    step(1, 0, 8'hFF, 0);
    check_eq("ovf_set", {f1_ovf, f0_ovf}, 2'b11);
    check_eq("ovf_occ_f1", f1_occ, 16);
    check_eq("ovf_occ_f0", f0_occ, 16);
    step(0, 0, 0, 1);
    check_eq("ovf_clr", {f1_ovf, f0_ovf}, 2'b00);
    check_eq("full_head_f1", f1_dout, 8'h00);
    step(1, 1, 8'hEE, 0);
    check_eq("full_rw_occ_f1", f1_occ, 15);
    check_eq("full_rw_occ_f0", f0_occ, 15);
    check_eq("full_rw_ovf", {f1_ovf, f0_ovf}, 2'b11);
    check_eq("full_rw_full", {f1_full, f0_full}, 2'b00);
    for (int i = 1; i < 16; i++) begin
      check_eq("drain_f1", f1_dout, i);
      step(0, 1, 0, 0);
      check_eq("drain_f0", f0_dout, i - 1);
      check_eq("drain_ae", {f1_ae, f0_ae}, ((15 - i) <= 2) ? 2'b11 : 2'b00);
    end
    step(0, 0, 0, 0);
    check_eq("drain_last_f0", f0_dout, 8'h0F);
    check_eq("drain_done", {f1_empty, f0_empty, f1_occ, f0_occ}, 12'hC00);
    check_eq("drain_unf", {f1_unf, f0_unf}, 2'b00);

    // Streaming at occupancy 8 across pointer wrap
    step(0, 0, 0, 1);
    for (int k = 0; k < 8; k++) begin
      step(1, 0, 8'h80 + 8'(k), 0);
      q.push_back(8'h80 + 8'(k));
    end
    repeat (3) step(0, 0, 0, 0);
    last_pop = '0;
    for (int c = 0; c < 40; c++) begin
      check_eq("stream_f1", f1_dout, q[0]);
      popped = q.pop_front();
      q.push_back(8'h40 + 8'(c));
      step(1, 1, 8'h40 + 8'(c), 0);
      if (c > 0) check_eq("stream_f0", f0_dout, last_pop);
      last_pop = popped;
    end
    check_eq("stream_occ_f1", f1_occ, 8);
    check_eq("stream_occ_f0", f0_occ, 8);
    check_eq("stream_err", {f1_ovf, f1_unf, f0_ovf, f0_unf}, 0);

    // Underflow stickiness and clear priority
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 0, 0);
    check_eq("unf_set", {f1_unf, f0_unf}, 2'b11);
    step(0, 0, 0, 0);
    check_eq("unf_sticky", {f1_unf, f0_unf}, 2'b11);
    step(0, 0, 0, 1);
    check_eq("unf_clr", {f1_unf, f0_unf}, 2'b00);
    step(0, 1, 0, 1);
    check_eq("unf_set_wins", {f1_unf, f0_unf}, 2'b11);
    step(0, 0, 0, 1);
    step(1, 1, 8'h33, 0);
    check_eq("empty_rw_unf", {f1_unf, f0_unf}, 2'b11);
    check_eq("empty_rw_occ_f1", f1_occ, 1);
    check_eq("empty_rw_occ_f0", f0_occ, 1);
    check_eq("empty_rw_empty", {f1_empty, f0_empty}, 2'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
